// File: rtl/dmem_latency_model_if.sv
// dmem_latency_model_if
//   CPU data-memory bus between the RV32IM pipeline and dmem_latency_model.
//   Optional macro: DMEM_STATS_EN adds the access/stall statistics counters.
//
//   READ       [3]=read request, [2:0]=load funct3        (CPU -> memory)
//   WRITE      [2]=write request, [1:0]=store size        (CPU -> memory)
//   ADDR       byte address                               (CPU -> memory)
//   WRITEDATA  store data, bytes taken from the LSBs      (CPU -> memory)
//   READDATA   sign/zero-extended load result             (memory -> CPU)
//   BUSYWAIT   stall request                              (memory -> CPU)
//   ERR        misaligned/illegal access pulse in ACK     (memory -> CPU)
//   READ_COUNT, WRITE_COUNT, STALL_COUNT (DMEM_STATS_EN only, memory -> CPU)
interface dmem_latency_model_if;
    logic [3:0]  READ;
    logic [2:0]  WRITE;
    logic [31:0] ADDR;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        ERR;
`ifdef DMEM_STATS_EN
    logic [31:0] READ_COUNT;
    logic [31:0] WRITE_COUNT;
    logic [31:0] STALL_COUNT;

    modport master (
        output READ, WRITE, ADDR, WRITEDATA,
        input  READDATA, BUSYWAIT, ERR, READ_COUNT, WRITE_COUNT, STALL_COUNT
    );
    modport slave (
        input  READ, WRITE, ADDR, WRITEDATA,
        output READDATA, BUSYWAIT, ERR, READ_COUNT, WRITE_COUNT, STALL_COUNT
    );
`else
    modport master (
        output READ, WRITE, ADDR, WRITEDATA,
        input  READDATA, BUSYWAIT, ERR
    );
    modport slave (
        input  READ, WRITE, ADDR, WRITEDATA,
        output READDATA, BUSYWAIT, ERR
    );
`endif
endinterface

// File: rtl/dmem_latency_model.sv
// dmem_latency_model
//   Data-memory model with a multi-cycle BUSYWAIT handshake (IDLE -> BUSY ->
//   ACK) for exercising the pipeline stall path. Decodes byte/halfword/word
//   loads and stores, little-endian lanes, and flags misaligned or illegal
//   requests with a one-cycle ERR pulse in ACK.
//   Optional macro: DMEM_STATS_EN enables saturating read/write/stall counters.
//
//   Parameters: DEPTH   memory size in 32-bit words (power of two, >= 4)
//               LATENCY wait cycles per access (>= 1)
//   Ports:      CLK     rising-edge clock
//               RESET   synchronous active-low reset
//               bus     dmem_latency_model_if.slave (CPU data-memory port)
module dmem_latency_model #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    dmem_latency_model_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            busy;
    logic            req;
    logic            op_rd, op_wr;
    logic [2:0]      fn_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            err_now;
    logic            commit;
    logic [31:0]     mem [DEPTH];

    function automatic logic access_err(input logic rd, input logic wr,
                                        input logic [2:0] fn, input logic [1:0] size,
                                        input logic [1:0] a);
        logic e;
        e = 1'b0;
        if (rd && wr) begin
            e = 1'b1;
        end else if (rd) begin
            case (fn)
                3'b000, 3'b100: e = 1'b0;
                3'b001, 3'b101: e = a[0];
                3'b010:         e = (a != 2'b00);
                default:        e = 1'b1;
            endcase
        end else if (wr) begin
            case (size)
                2'b00:   e = 1'b0;
                2'b01:   e = a[0];
                2'b10:   e = (a != 2'b00);
                default: e = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0] fn, input logic [1:0] a);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        b_s = word[8*a +: 8];
        h_s = a[1] ? word[31:16] : word[15:0];
        case (fn)
            3'b000:  return 32'(b_s);               // LB: sign-extend
            3'b001:  return 32'(h_s);               // LH: sign-extend
            3'b100:  return {24'd0, b_s};           // LBU
            3'b101:  return {16'd0, h_s};           // LHU
            default: return word;                   // LW
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] a);
        logic [31:0] res;
        logic [31:0] lane;
        logic [3:0]  be;
        res = old;
        case (size)
            2'b00:   begin be = 4'b0001 << a;                    lane = {4{wd[7:0]}};  end
            2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011;        lane = {2{wd[15:0]}}; end
            default: begin be = 4'b1111;                         lane = wd;            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = lane[8*i +: 8];
        end
        return res;
    endfunction

    assign req     = bus.READ[3] | bus.WRITE[2];
    assign err_now = access_err(op_rd, op_wr, fn_q, size_q, addr_q[1:0]);
    // The access happens on the BUSY->ACK edge; a reset on that edge abandons it.
    assign commit  = RESET && (state == BUSY) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                busy = req;
                if (req) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.BUSYWAIT = busy & RESET;
    assign bus.READDATA = rdata_q;
    assign bus.ERR      = err_q;

    // Control: state, wait counter, registered response
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req) cnt <= CNT_LOAD;
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rdata_q <= (op_rd && !err_now)
                                   ? load_ext(mem[addr_q[AW+1:2]], fn_q, addr_q[1:0]) : '0;
                        err_q   <= err_now;
                    end
                end
                ACK:     err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Request capture: only an IDLE-cycle request is latched
    always_ff @(posedge CLK) begin
        if (state == IDLE && req) begin
            op_rd   <= bus.READ[3];
            op_wr   <= bus.WRITE[2];
            fn_q    <= bus.READ[2:0];
            size_q  <= bus.WRITE[1:0];
            addr_q  <= bus.ADDR[AW+1:0];
            wdata_q <= bus.WRITEDATA;
        end
    end

    // Storage: contents survive reset
    always_ff @(posedge CLK) begin
        if (commit && op_wr && !err_now) begin
            mem[addr_q[AW+1:2]] <= store_merge(mem[addr_q[AW+1:2]], wdata_q,
                                               size_q, addr_q[1:0]);
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt, wr_cnt, st_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Statistics
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (state == ACK && op_rd) rd_cnt <= sat_inc(rd_cnt);
            if (state == ACK && op_wr) wr_cnt <= sat_inc(wr_cnt);
            if (bus.BUSYWAIT)          st_cnt <= sat_inc(st_cnt);
        end
    end

    assign bus.READ_COUNT  = rd_cnt;
    assign bus.WRITE_COUNT = wr_cnt;
    assign bus.STALL_COUNT = st_cnt;
`endif
endmodule

// File: tb/tb_dmem_latency_model.sv
// tb_dmem_latency_model
//   Directed and randomized checks of dmem_latency_model against a byte-array
//   reference model of the load/store/error rules.
module tb_dmem_latency_model;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int NB      = DEPTH * 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_latency_model_if bus();

    dmem_latency_model #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] mb [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [1:0] code);
        return (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : 4;
    endfunction

    // Reference: byte-addressed memory, address wraps modulo NB.
    task automatic model(input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err);
        int unsigned base;
        int n;
        logic illegal;
        base    = a % NB;
        exp_rd  = '0;
        exp_err = 1'b0;
        if (rd[3] && wr[2]) begin
            exp_err = 1'b1;
        end else if (rd[3]) begin
            illegal = (rd[2:0] == 3'b011) || (rd[2:0] == 3'b110) || (rd[2:0] == 3'b111);
            n = op_size(rd[1:0]);
            if (illegal || (a % n) != 0) begin
                exp_err = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = mb[(base + i) % NB];
                if (!rd[2] && exp_rd[8*n-1])
                    for (int i = n; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
            end
        end else if (wr[2]) begin
            illegal = (wr[1:0] == 2'b11);
            n = op_size(wr[1:0]);
            if (illegal || (a % n) != 0) begin
                exp_err = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) mb[(base + i) % NB] = wd[8*i +: 8];
            end
        end
    endtask

    // Issue one access right after a rising edge; count stall cycles, sample the ACK cycle.
    task automatic run(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd, rdata;
        logic exp_err, e;
        int stalls;
        model(rd, wr, a, wd, exp_rd, exp_err);
        bus.READ = rd; bus.WRITE = wr; bus.ADDR = a; bus.WRITEDATA = wd;
        stalls = 0;
        @(negedge clk);
        while (bus.BUSYWAIT === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        rdata = bus.READDATA;
        e     = bus.ERR;
        @(posedge clk); #1;
        bus.READ = '0; bus.WRITE = '0;
        chk({tag, "_stall"}, stalls, LATENCY + 1);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        if (rd[3] || exp_err) chk({tag, "_data"}, rdata, exp_rd);
        if (exp_err) chk({tag, "_errpulse"}, {31'd0, bus.ERR}, 32'd0);
        got = rdata;
    endtask

    initial begin
        logic [31:0] g, old30, old40, old50, a;
        logic [3:0]  rd;
        logic [2:0]  wr;
        int          kind;

        bus.READ = '0; bus.WRITE = '0; bus.ADDR = '0; bus.WRITEDATA = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.READ = 4'b1010;
        @(negedge clk);
        chk("rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        chk("rst_readdata", bus.READDATA, 32'd0);
        chk("rst_err", {31'd0, bus.ERR}, 32'd0);
        bus.READ = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) run("fill", 4'b0000, 3'b110, w * 4, $urandom(), g);

        run("sw10", 4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, g);
        run("lw10", 4'b1010, 3'b000, 32'h10, 32'h0, g);
        chk("plan_lw10", g, 32'hDEADBEEF);
        run("sb11", 4'b0000, 3'b100, 32'h11, 32'h7F, g);
        run("lb11", 4'b1000, 3'b000, 32'h11, 32'h0, g);
        chk("plan_lb11", g, 32'h0000007F);
        run("sb12", 4'b0000, 3'b100, 32'h12, 32'h80, g);
        run("lb12", 4'b1000, 3'b000, 32'h12, 32'h0, g);
        chk("plan_lb12", g, 32'hFFFFFF80);
        run("lbu12", 4'b1100, 3'b000, 32'h12, 32'h0, g);
        chk("plan_lbu12", g, 32'h00000080);
        run("lw10b", 4'b1010, 3'b000, 32'h10, 32'h0, g);
        chk("plan_lw10b", g, 32'hDE807FEF);

        run("sh22", 4'b0000, 3'b101, 32'h22, 32'h8001, g);
        run("lh22", 4'b1001, 3'b000, 32'h22, 32'h0, g);
        chk("plan_lh22", g, 32'hFFFF8001);
        run("lhu22", 4'b1101, 3'b000, 32'h22, 32'h0, g);
        chk("plan_lhu22", g, 32'h00008001);
        run("lh23", 4'b1001, 3'b000, 32'h23, 32'h0, g);
        chk("plan_lh23", g, 32'h0);

        run("sw400", 4'b0000, 3'b110, 32'h400, 32'h12345678, g);
        run("lw000", 4'b1010, 3'b000, 32'h000, 32'h0, g);
        chk("plan_wrap", g, 32'h12345678);

        run("lw30a", 4'b1010, 3'b000, 32'h30, 32'h0, old30);
        run("sw31", 4'b0000, 3'b110, 32'h31, 32'hA5A5A5A5, g);
        run("lw30b", 4'b1010, 3'b000, 32'h30, 32'h0, g);
        chk("plan_misaligned_noupd", g, old30);
        run("rd011", 4'b1011, 3'b000, 32'h30, 32'h0, g);
        chk("plan_illegal_rdata", g, 32'h0);
        run("lw50a", 4'b1010, 3'b000, 32'h50, 32'h0, old50);
        run("both", 4'b1010, 3'b110, 32'h50, 32'h55AA55AA, g);
        run("lw50b", 4'b1010, 3'b000, 32'h50, 32'h0, g);
        chk("plan_both_noupd", g, old50);

        // Reset during BUSY abandons the store
        run("lw40a", 4'b1010, 3'b000, 32'h40, 32'h0, old40);
        bus.WRITE = 3'b110; bus.ADDR = 32'h40; bus.WRITEDATA = 32'hCAFEF00D;
        @(negedge clk);
        chk("mid_req_busywait", {31'd0, bus.BUSYWAIT}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.WRITE = '0;
        @(negedge clk);
        chk("mid_rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        chk("mid_idle_readdata", bus.READDATA, 32'd0);
        chk("mid_idle_err", {31'd0, bus.ERR}, 32'd0);
        @(posedge clk); #1;
        run("lw40b", 4'b1010, 3'b000, 32'h40, 32'h0, g);
        chk("plan_rst_noupd", g, old40);

        run("b2b0", 4'b1010, 3'b000, 32'h44, 32'h0, g);
        run("b2b1", 4'b1010, 3'b000, 32'h48, 32'h0, g);
        run("b2b2", 4'b1010, 3'b000, 32'h4C, 32'h0, g);

        for (int k = 0; k < 150; k++) begin
            kind = int'($urandom_range(0, 9));
            a    = $urandom();
            rd   = '0;
            wr   = '0;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (kind < 5) begin
                rd = {1'b1, 3'($urandom_range(0, 7))};
            end else if (kind < 9) begin
                wr = {1'b1, 2'($urandom_range(0, 3))};
            end else begin
                rd = {1'b1, 3'($urandom_range(0, 7))};
                wr = {1'b1, 2'($urandom_range(0, 3))};
            end
            run("rnd", rd, wr, a, $urandom(), g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
